ext_pipe: RTL



---
 rtl/ext_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ext_pipe.sv
// ext_pipe: two-stage immediate extender with valid/ready handshakes on both sides.
// Optional macro EXT_UPPER_EN enables the upper-immediate mode (ExtSel 3'b011).
module ext_pipe #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int SA_LSB = 6,
  parameter int SA_W   = 5
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  i_num,
  input  logic [2:0]       ExtSel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] o_num,
  output logic [2:0]       o_sel,
  output logic             ill_sel
);

  localparam logic [2:0] SEL_SA     = 3'b000;
  localparam logic [2:0] SEL_ZEXT   = 3'b001;
  localparam logic [2:0] SEL_SEXT   = 3'b010;
  localparam logic [2:0] SEL_UPPER  = 3'b011;
  localparam logic [2:0] SEL_BRANCH = 3'b100;

  function automatic logic [OUT_W-1:0] f_sext(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = {OUT_W{v[IN_W-1]}};
    r[IN_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] f_zext(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = '0;
    r[IN_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] f_sa(input logic [SA_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = '0;
    r[SA_W-1:0] = v;
    return r;
  endfunction

`ifdef EXT_UPPER_EN
  function automatic logic [OUT_W-1:0] f_upper(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = '0;
    r[OUT_W-1 -: IN_W] = v;
    return r;
  endfunction
`endif

  function automatic logic f_illegal(input logic [2:0] sel);
    logic r;
    case (sel)
      SEL_SA, SEL_ZEXT, SEL_SEXT, SEL_BRANCH: r = 1'b0;
`ifdef EXT_UPPER_EN
      SEL_UPPER: r = 1'b0;
`endif
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  logic             r_s1_valid;
  logic [IN_W-1:0]  r_s1_num;
  logic [2:0]       r_s1_sel;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_o_num;
  logic [2:0]       r_o_sel;
  logic             r_ill_sel;

  logic             w_s2_adv;
  logic             w_accept;
  logic [OUT_W-1:0] w_ext;

  // S2 may load whenever it is empty or its current result is being taken.
  assign w_s2_adv  = !r_out_valid || out_ready;
  assign in_ready  = !Reset && (!r_s1_valid || w_s2_adv);
  assign w_accept  = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign o_num     = r_o_num;
  assign o_sel     = r_o_sel;
  assign ill_sel   = r_ill_sel;

  // Mode function applied to the operand waiting in S1.
  always_comb begin
    w_ext = f_sext(r_s1_num);
    case (r_s1_sel)
      SEL_SA:     w_ext = f_sa(r_s1_num[SA_LSB +: SA_W]);
      SEL_ZEXT:   w_ext = f_zext(r_s1_num);
      SEL_SEXT:   w_ext = f_sext(r_s1_num);
`ifdef EXT_UPPER_EN
      SEL_UPPER:  w_ext = f_upper(r_s1_num);
`endif
      SEL_BRANCH: w_ext = f_sext(r_s1_num) << 2'd2;
      default:    w_ext = f_sext(r_s1_num);
    endcase
  end

  // S1: capture on accept, empty once its operand moves into S2.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_s1_valid <= 1'b0;
      r_s1_num   <= '0;
      r_s1_sel   <= 3'b000;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_num   <= i_num;
      r_s1_sel   <= ExtSel;
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2: output register, held stable while stalled.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_o_num     <= '0;
      r_o_sel     <= 3'b000;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_o_num <= w_ext;
        r_o_sel <= r_s1_sel;
      end
    end
  end

  // Sticky flag for any accepted undefined selector.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_ill_sel <= 1'b0;
    end else if (w_accept && f_illegal(ExtSel)) begin
      r_ill_sel <= 1'b1;
    end
  end

endmodule
